// File: rtl/issue_queue_collapse.sv
// Four-entry collapsing issue queue: in-order append from dispatch, oldest-ready issue,
// with younger entries shifting down so valid slots always sit at 0..count-1.
module issue_queue_collapse #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [DATA_W-1:0] disp_data,
  output logic              disp_ready,
  input  logic [3:0]        entry_rdy,
  input  logic              issue_en,
  input  logic              flush,
  output logic              iss_valid,
  output logic [DATA_W-1:0] iss_data,
  output logic [1:0]        iss_slot,
  output logic [2:0]        count
);

  logic [DATA_W-1:0] entry_q [4];
  logic [DATA_W-1:0] entry_d [4];
  logic [2:0]        count_q, count_d;
  logic [3:0]        valid;
  logic [1:0]        sel;
  logic              found;
  logic              iss_fire, disp_fire;
  logic [2:0]        wr_idx;

  // Valid bits are the thermometer code of count, so they are derived rather than stored.
  always_comb begin
    for (int i = 0; i < 4; i++) valid[i] = (3'(i) < count_q);
  end

  // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    sel   = 2'd0;
    found = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (valid[i] && entry_rdy[i]) begin
        sel   = 2'(i);
        found = 1'b1;
      end
    end
  end

  assign iss_valid  = found & ~flush;
  assign iss_slot   = sel;
  assign iss_data   = entry_q[sel];
  assign disp_ready = (count_q != 3'd4) & ~flush & ~rst;
  assign count      = count_q;

  assign iss_fire  = iss_valid & issue_en;
  assign disp_fire = disp_valid & disp_ready;
  assign wr_idx    = count_q - {2'b00, iss_fire};

  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (flush) begin
      count_d = 3'd0;
    end else begin
      // Collapse first; the append index already accounts for the vacated slot.
      if (iss_fire) begin
        for (int j = 0; j < 3; j++) begin
          if (2'(j) >= sel) entry_d[j] = entry_q[j+1];
        end
      end
      if (disp_fire) entry_d[wr_idx[1:0]] = disp_data;
      count_d = count_q + {2'b00, disp_fire} - {2'b00, iss_fire};
    end
  end

  // NOTE: payload registers are reset too, because iss_data must read zero out of reset.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 3'd0;
      for (int i = 0; i < 4; i++) entry_q[i] <= '0;
    end else begin
      count_q <= count_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: tb/tb_issue_queue_collapse.sv
// Bench for issue_queue_collapse: directed vector table, async reset sequence,
// then randomized traffic checked against a queue-based reference model.
module tb_issue_queue_collapse;

  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_valid;
  logic [DATA_W-1:0] disp_data;
  logic              disp_ready;
  logic [3:0]        entry_rdy;
  logic              issue_en;
  logic              flush;
  logic              iss_valid;
  logic [DATA_W-1:0] iss_data;
  logic [1:0]        iss_slot;
  logic [2:0]        count;

  int errors = 0;
  int checks = 0;

  logic [DATA_W-1:0] model_q [$];

  typedef struct {
    logic              dv;
    logic [DATA_W-1:0] dd;
    logic [3:0]        rdy;
    logic              ie;
    logic              fl;
    logic              exp_iv;
    logic [1:0]        exp_slot;
    logic [DATA_W-1:0] exp_data;
    logic              exp_dr;
    logic [2:0]        exp_cnt;
  } vec_t;

  vec_t vecs [18];

  issue_queue_collapse #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .disp_ready (disp_ready),
    .entry_rdy  (entry_rdy),
    .issue_en   (issue_en),
    .flush      (flush),
    .iss_valid  (iss_valid),
    .iss_data   (iss_data),
    .iss_slot   (iss_slot),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic dv, input logic [DATA_W-1:0] dd, input logic [3:0] rdy,
                       input logic ie, input logic fl);
    @(negedge clk);
    disp_valid = dv;
    disp_data  = dd;
    entry_rdy  = rdy;
    issue_en   = ie;
    flush      = fl;
    #1;
  endtask

  // One cycle checked against the model: oldest ready entry issues, dispatch appends
  // only if the queue was not full at the start of the cycle, flush empties everything.
  task automatic model_step(input logic dv, input logic [DATA_W-1:0] dd, input logic [3:0] rdy,
                            input logic ie, input logic fl);
    int  s;
    bit  exp_iv, exp_dr;
    drive(dv, dd, rdy, ie, fl);
    s = -1;
    for (int i = 0; i < model_q.size(); i++) begin
      if (rdy[i]) begin
        s = i;
        break;
      end
    end
    exp_iv = !fl && (s >= 0);
    exp_dr = !fl && (model_q.size() < 4);
    check("rand_count", 64'(count), 64'(model_q.size()));
    check("rand_iss_valid", 64'(iss_valid), 64'(exp_iv));
    check("rand_disp_ready", 64'(disp_ready), 64'(exp_dr));
    if (exp_iv) begin
      check("rand_iss_slot", 64'(iss_slot), 64'(s));
      check("rand_iss_data", 64'(iss_data), 64'(model_q[s]));
    end
    if (fl) begin
      model_q.delete();
    end else begin
      if (exp_iv && ie) model_q.delete(s);
      if (dv && exp_dr) model_q.push_back(dd);
    end
  endtask

  localparam logic [DATA_W-1:0] A = 32'hA000_000A, B = 32'hB000_000B, C = 32'hC000_000C;
  localparam logic [DATA_W-1:0] D = 32'hD000_000D, E = 32'hE000_000E, F = 32'hF000_000F;
  localparam logic [DATA_W-1:0] G = 32'h6000_0006;

  initial begin
    //            dv  dd  rdy      ie  fl  iv  slot data dr  cnt
    vecs[0]  = '{1'b0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 3'd0};
    vecs[1]  = '{1'b1, A, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 3'd0};
    vecs[2]  = '{1'b1, B, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 3'd1};
    vecs[3]  = '{1'b1, C, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 3'd2};
    vecs[4]  = '{1'b1, D, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 3'd3};
    vecs[5]  = '{1'b0, 0, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b0, 3'd4};
    vecs[6]  = '{1'b0, 0, 4'b0110, 1'b1, 1'b0, 1'b1, 2'd1, B, 1'b0, 3'd4};
    vecs[7]  = '{1'b1, F, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 3'd3};
    vecs[8]  = '{1'b1, E, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, A, 1'b0, 3'd4};
    vecs[9]  = '{1'b0, 0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, C, 1'b1, 3'd3};
    vecs[10] = '{1'b0, 0, 4'b1000, 1'b1, 1'b0, 1'b0, 2'd0, 0, 1'b1, 3'd3};
    vecs[11] = '{1'b0, 0, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, C, 1'b1, 3'd3};
    vecs[12] = '{1'b1, E, 4'b0001, 1'b1, 1'b0, 1'b1, 2'd0, D, 1'b1, 3'd2};
    vecs[13] = '{1'b0, 0, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1, E, 1'b1, 3'd2};
    vecs[14] = '{1'b0, 0, 4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, F, 1'b1, 3'd2};
    vecs[15] = '{1'b1, G, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 3'd2};
    vecs[16] = '{1'b1, A, 4'b1111, 1'b1, 1'b1, 1'b0, 2'd0, 0, 1'b0, 3'd3};
    vecs[17] = '{1'b0, 0, 4'b1111, 1'b0, 1'b0, 1'b0, 2'd0, 0, 1'b1, 3'd0};

    rst        = 1'b1;
    disp_valid = 1'b0;
    disp_data  = '0;
    entry_rdy  = 4'b0000;
    issue_en   = 1'b0;
    flush      = 1'b0;
    #1;
    check("reset_count", 64'(count), 64'd0);
    check("reset_iss_valid", 64'(iss_valid), 64'd0);
    check("reset_iss_slot", 64'(iss_slot), 64'd0);
    check("reset_iss_data", 64'(iss_data), 64'd0);
    check("reset_disp_ready", 64'(disp_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 18; k++) begin
      drive(vecs[k].dv, vecs[k].dd, vecs[k].rdy, vecs[k].ie, vecs[k].fl);
      check($sformatf("vec%0d_count", k), 64'(count), 64'(vecs[k].exp_cnt));
      check($sformatf("vec%0d_iss_valid", k), 64'(iss_valid), 64'(vecs[k].exp_iv));
      check($sformatf("vec%0d_disp_ready", k), 64'(disp_ready), 64'(vecs[k].exp_dr));
      if (vecs[k].exp_iv) begin
        check($sformatf("vec%0d_iss_slot", k), 64'(iss_slot), 64'(vecs[k].exp_slot));
        check($sformatf("vec%0d_iss_data", k), 64'(iss_data), 64'(vecs[k].exp_data));
      end
    end

    // Asynchronous reset mid-stream, asserted between clock edges.
    model_q.delete();
    model_step(1'b1, A, 4'b0000, 1'b0, 1'b0);
    model_step(1'b1, B, 4'b0000, 1'b0, 1'b0);
    model_step(1'b1, C, 4'b0001, 1'b0, 1'b0);
    @(negedge clk);
    disp_valid = 1'b1;
    disp_data  = D;
    entry_rdy  = 4'b0001;
    issue_en   = 1'b1;
    #1;
    check("pre_arst_iss_valid", 64'(iss_valid), 64'd1);
    check("pre_arst_count", 64'(count), 64'd3);
    rst = 1'b1;
    #1;
    check("arst_count", 64'(count), 64'd0);
    check("arst_iss_valid", 64'(iss_valid), 64'd0);
    check("arst_disp_ready", 64'(disp_ready), 64'd0);
    check("arst_iss_data", 64'(iss_data), 64'd0);
    @(negedge clk);
    rst        = 1'b0;
    disp_valid = 1'b0;
    issue_en   = 1'b0;
    #1;
    check("post_arst_disp_ready", 64'(disp_ready), 64'd1);
    check("post_arst_count", 64'(count), 64'd0);
    model_q.delete();

    for (int n = 0; n < 3000; n++) begin
      model_step(1'($urandom_range(0, 3) != 0), $urandom, 4'($urandom),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_queue_collapse.md
# issue_queue_collapse

Four-entry, in-order-compacting (collapsing) issue queue between dispatch and the execution back end. It accepts one instruction per cycle from dispatch over a valid/ready handshake. Each cycle it issues the oldest entry whose operands are ready. After an issue it shifts younger entries down so that valid entries always occupy slots 0..count-1, with slot 0 the oldest. It is the writer/holder side of the slot-index compaction performed by the entry-selection logic: it owns the entries and the shifting those indices describe.

## Interface
- DATA_W, default 32, width of the instruction payload held per entry
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- One clock; reset is asynchronous and active-high.
- disp_valid  in  1  dispatch offers an instruction
- disp_data  in  DATA_W  instruction payload
- disp_ready  out  1  queue can accept this cycle
- entry_rdy  in  4  operands-ready per current slot (bit i = slot i), from the checkers
- issue_en  in  1  back end accepts an issue this cycle
- flush  in  1  synchronous clear of all entries
- iss_valid  out  1  an issuable entry is presented
- iss_data  out  DATA_W  payload of the presented entry
- iss_slot  out  2  slot index of the presented entry
- count  out  3  number of valid entries, 0..4

## Operation
- State:
  - entry[0..3] (DATA_W each)
  - valid[3:0]; valid is always thermometer-coded, equal to the low `count` bits set
  - count register
- Issue select (combinational):
  - sel is the lowest i with valid[i] & entry_rdy[i].
  - iss_valid = 1 if any such i exists. iss_slot = sel; iss_data = entry[sel].
  - entry_rdy bits on invalid slots are ignored.
- iss_fire = iss_valid & issue_en & ~flush.
- disp_ready = (count != 4) & ~flush & ~rst.
  - No same-cycle issue credit: a full queue refuses dispatch even if it issues in that cycle.
- disp_fire = disp_valid & disp_ready.
- Next state, when no flush:
  - On iss_fire, entry[j] <= entry[j+1] for every j >= sel, and the top slot is vacated.
  - On disp_fire, disp_data is written at slot (count − iss_fire).
  - count <= count + disp_fire − iss_fire.
- Simultaneous issue and dispatch:
  - Collapse first, then append.
  - The new entry lands directly above the survivors; count is unchanged.
- Flush:
  - Next cycle count = 0 and valid = 0.
  - iss_valid is forced to 0 and disp_ready to 0 in the flush cycle, so no transfer occurs.
  - Payload registers may keep stale data.
- The oldest-first invariant holds at all times: entry order equals dispatch order among survivors.
- count never exceeds 4 and never underflows, because issue requires a valid slot.
- Upstream wakeup logic must re-index entry_rdy after each collapse. This is outside the block.

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - count = 0, valid = 0, entry payloads = 0
  - iss_valid = 0, iss_slot = 0, iss_data = 0
  - disp_ready = 0 while rst is high, and 1 in the first cycle after release
- Dispatch-to-issue latency is 1 cycle minimum: a dispatched entry can be presented the cycle after disp_fire.
  - There is no bypass when the queue is empty.
- iss_* are combinational from registered entries and the entry_rdy input. The same-cycle entry_rdy → iss_valid path is required.
- Issue-to-collapse: the issuing slot is removed at the same edge as iss_fire. The next cycle shows the shifted entries.
- disp_ready depends only on the count register, flush and rst. It never depends on issue_en or entry_rdy.
- Throughput: 1 dispatch plus 1 issue per cycle sustained when count is 1..3.
- Reset asserted mid-operation clears all state immediately, regardless of the clock. An in-flight handshake in that cycle is dropped.

## Test plan
- Reset, then release; disp_valid = 0 → count = 0, iss_valid = 0, disp_ready = 1 one cycle after release.
- Dispatch A, B, C, D on consecutive cycles with entry_rdy = 0 → count reaches 4; disp_ready = 0 the cycle after D; iss_valid stays 0.
- Full queue, entry_rdy = 4'b0110, issue_en = 1 → iss_slot = 1, iss_data = B. Next cycle the slots hold A, C, D, count = 3, and disp_ready = 1.
- Full queue, entry_rdy = 4'b0001, issue_en = 1, disp_valid = 1 with E → A issues; E is not accepted; next count = 3 with slots B, C, D.
- count = 2 (A, B), entry_rdy = 4'b0001, issue_en = 1, disp_valid = 1 with E → A issues and E is accepted; next slots B, E, count = 2.
- Flush with count = 3 and disp_valid = 1 → iss_valid = 0 and disp_ready = 0 that cycle; next count = 0.
- Asynchronous rst mid-stream → count = 0 and iss_valid = 0 without waiting for a clock edge.
